// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter and its helpers.
//   arb_state_t      : arbiter FSM states
//   UART_DATA_W      : default byte width
//   UART_TIMEOUT_CYC : default watchdog limit (used only with UART_ARB_TIMEOUT_EN)
//   idx_width()      : index width for an N-entry vector, never below 1 bit
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      GRANT      = 3'd1,
      LOAD       = 3'd2,
      WAIT_START = 3'd3,
      WAIT_DONE  = 3'd4
   } arb_state_t;

   localparam int UART_DATA_W      = 8;
   localparam int UART_TIMEOUT_CYC = 65535;

   // A single requester still needs a 1-bit index signal.
   function automatic int idx_width(input int n);
      int w;
      if (n > 1) begin
         w = $clog2(n);
      end else begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundle of requester handshake and transmitter-side signals of the arbiter.
//   req_valid/req_data : requester byte offers (requester i at [i*DATA_W +: DATA_W])
//   req_ready          : one-hot accept strobe back to requesters
//   tx_empty           : transmitter idle flag
//   tx_ld/tx_data      : load strobe and byte to the transmitter
//   grant_id/busy      : arbiter status
//   timeout_err        : sticky watchdog flag
// Modports: master = client/transmitter side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = UART_DATA_W
);
   localparam int GID_W = idx_width(N_REQ);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    tx_empty;
   logic                    tx_ld;
   logic [DATA_W-1:0]       tx_data;
   logic [GID_W-1:0]        grant_id;
   logic                    busy;
   logic                    timeout_err;

   modport master (
      output req_valid, req_data, tx_empty,
      input  req_ready, tx_ld, tx_data, grant_id, busy, timeout_err
   );

   modport slave (
      input  req_valid, req_data, tx_empty,
      output req_ready, tx_ld, tx_data, grant_id, busy, timeout_err
   );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority selector: returns the first set bit of
// req scanning ptr, ptr+1, ... modulo N_REQ.
//   req       : request vector
//   ptr       : index that has highest priority (must be < N_REQ)
//   winner    : selected index (0 when nothing is requested)
//   any_valid : at least one request bit set
// -----------------------------------------------------------------------------
module rr_pick
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any_valid
);

   // Scan from the farthest offset back to ptr so the closest request wins last.
   always_comb begin
      logic [IDX_W-1:0] idx;
      winner    = '0;
      any_valid = |req;
      idx       = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx    = IDX_W'((int'(ptr) + k) % N_REQ);
         winner = req[idx] ? idx : winner;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ requesters with round-robin
// arbitration, sequencing the load strobe and tracking tx_empty so that only
// one byte is ever in flight.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : uart_tx_arbiter_if.slave (requester handshake + transmitter side)
// Optional feature: define UART_ARB_TIMEOUT_EN to add parameter TIMEOUT_CYC
// and a watchdog over the WAIT_START/WAIT_DONE states that sets the sticky
// timeout_err flag and abandons the stuck frame. Without it timeout_err is 0.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = UART_DATA_W
`ifdef UART_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC
`endif
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int GID_W = idx_width(N_REQ);

   arb_state_t        state_r;
   arb_state_t        state_s;
   logic [GID_W-1:0]  rr_ptr_r;
   logic [GID_W-1:0]  rr_ptr_s;
   logic [GID_W-1:0]  grant_id_r;
   logic [GID_W-1:0]  grant_id_s;
   logic [GID_W-1:0]  pick_id_s;
   logic              pick_any_s;
   logic [N_REQ-1:0]  req_ready_r;
   logic [N_REQ-1:0]  req_ready_s;
   logic              tx_ld_r;
   logic              tx_ld_s;
   logic [DATA_W-1:0] tx_data_r;
   logic [DATA_W-1:0] tx_data_s;
   logic              busy_r;
   logic              gnt_valid_s;
   logic [DATA_W-1:0] gnt_data_s;
`ifdef UART_ARB_TIMEOUT_EN
   logic [31:0]       wait_cnt_r;
   logic [31:0]       wait_cnt_s;
   logic              timeout_err_r;
   logic              timeout_err_s;
   logic              timeout_hit_s;
`endif

   // Index after idx, wrapping at N_REQ (stays 0 for a single requester).
   function automatic logic [GID_W-1:0] next_idx(input logic [GID_W-1:0] idx);
      logic [GID_W-1:0] nxt;
      if (int'(idx) >= N_REQ - 1) begin
         nxt = '0;
      end else begin
         nxt = idx + GID_W'(1'b1);
      end
      return nxt;
   endfunction

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (GID_W)
   ) u_rr_pick (
      .req       (bus.req_valid),
      .ptr       (rr_ptr_r),
      .winner    (pick_id_s),
      .any_valid (pick_any_s)
   );

   // Mux out the valid bit and byte of the currently granted requester.
   always_comb begin
      gnt_valid_s = 1'b0;
      gnt_data_s  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         gnt_valid_s = gnt_valid_s | (bus.req_valid[i] & (grant_id_r == GID_W'(i)));
         gnt_data_s  = gnt_data_s |
                       (bus.req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_id_r == GID_W'(i)}});
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   assign timeout_hit_s = (wait_cnt_r >= 32'(TIMEOUT_CYC - 1));
`endif

   // Next-state and next-output logic; outputs are registered from these values.
   always_comb begin
      state_s     = state_r;
      rr_ptr_s    = rr_ptr_r;
      grant_id_s  = grant_id_r;
      req_ready_s = '0;
      tx_ld_s     = 1'b0;
      tx_data_s   = tx_data_r;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt_s    = '0;
      timeout_err_s = timeout_err_r;
`endif
      case (state_r)
         IDLE: begin
            // Only grant onto an idle transmitter; this also covers reset mid-frame.
            if (bus.tx_empty && pick_any_s) begin
               state_s    = GRANT;
               grant_id_s = pick_id_s;
               for (int i = 0; i < N_REQ; i++) begin
                  req_ready_s[i] = (pick_id_s == GID_W'(i));
               end
            end else begin
               state_s = IDLE;
            end
         end
         GRANT: begin
            // req_ready is high this cycle, so valid here completes the transfer.
            if (gnt_valid_s) begin
               tx_data_s = gnt_data_s;
               tx_ld_s   = 1'b1;
               state_s   = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            state_s = WAIT_START;
         end
         WAIT_START: begin
            if (!bus.tx_empty) begin
               state_s = WAIT_DONE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (timeout_hit_s) begin
               timeout_err_s = 1'b1;
               rr_ptr_s      = next_idx(grant_id_r);
               state_s       = IDLE;
            end
`endif
            else begin
               state_s = WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
               wait_cnt_s = wait_cnt_r + 32'd1;
`endif
            end
         end
         WAIT_DONE: begin
            if (bus.tx_empty) begin
               rr_ptr_s = next_idx(grant_id_r);
               state_s  = IDLE;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (timeout_hit_s) begin
               timeout_err_s = 1'b1;
               rr_ptr_s      = next_idx(grant_id_r);
               state_s       = IDLE;
            end
`endif
            else begin
               state_s = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
               wait_cnt_s = wait_cnt_r + 32'd1;
`endif
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, pointer and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         rr_ptr_r    <= '0;
         grant_id_r  <= '0;
         req_ready_r <= '0;
         tx_ld_r     <= 1'b0;
         tx_data_r   <= '0;
         busy_r      <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         wait_cnt_r    <= '0;
         timeout_err_r <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         rr_ptr_r    <= rr_ptr_s;
         grant_id_r  <= grant_id_s;
         req_ready_r <= req_ready_s;
         tx_ld_r     <= tx_ld_s;
         tx_data_r   <= tx_data_s;
         busy_r      <= (state_s != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
         wait_cnt_r    <= wait_cnt_s;
         timeout_err_r <= timeout_err_s;
`endif
      end
   end

   assign bus.req_ready = req_ready_r;
   assign bus.tx_ld     = tx_ld_r;
   assign bus.tx_data   = tx_data_r;
   assign bus.grant_id  = grant_id_r;
   assign bus.busy      = busy_r;
`ifdef UART_ARB_TIMEOUT_EN
   assign bus.timeout_err = timeout_err_r;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=4, DATA_W=8). Expected grants and
// bytes are queued when a request is offered and compared when the arbiter
// loads the transmitter. The bench plays the transmitter via tx_empty.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int FRAME  = 4;
   localparam int LIMIT  = 20;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

   uart_tx_arbiter #(
      .N_REQ  (N_REQ),
      .DATA_W (DATA_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_tx_ld"}, 32'(bus.tx_ld), 32'd0);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
      chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
   endtask

   task automatic set_byte(input int idx, input logic [7:0] val);
      bus.req_data[idx*DATA_W +: DATA_W] = val;
   endtask

   // Waits (bounded) for any req_ready; n = cycles waited.
   task automatic wait_ready(output int n);
      n = 0;
      while (bus.req_ready == '0 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One full transfer checked against the head of the scoreboard.
   task automatic do_transfer(input bit drop, output int n);
      exp_t e;
      e = sb_q.pop_front();
      wait_ready(n);
      chk("req_ready", 32'(bus.req_ready), 32'd1 << e.id);
      chk("grant_id", 32'(bus.grant_id), 32'(e.id));
      chk("busy_grant", 32'(bus.busy), 32'd1);
      @(negedge clk);
      chk("tx_ld", 32'(bus.tx_ld), 32'd1);
      chk("tx_data", 32'(bus.tx_data), 32'(e.data));
      chk("ready_one_cycle", 32'(bus.req_ready), 32'd0);
      if (drop) bus.req_valid[e.id] = 1'b0;
      @(negedge clk);
      chk("tx_ld_pulse", 32'(bus.tx_ld), 32'd0);
      bus.tx_empty = 1'b0;
      repeat (FRAME) @(negedge clk);
      chk("busy_frame", 32'(bus.busy), 32'd1);
      bus.tx_empty = 1'b1;
      @(negedge clk);
      chk("busy_done", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int   n;
      exp_t e;
      rst           = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_empty  = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b1;
      @(negedge clk);
      chk_zero_outputs("idle");

      // All four valid continuously: rotation 0,1,2,3,0.
      for (int k = 0; k < 4; k++) set_byte(k, 8'(8'h10 + k));
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) sb_q.push_back('{id: 2'(k % 4), data: 8'(8'h10 + (k % 4))});
      for (int k = 0; k < 5; k++) begin
         do_transfer(1'b0, n);
         chk("rot_latency", 32'(n), 32'd1);
      end
      bus.req_valid = '0;

      // Single request from requester 2 (pointer now 1).
      set_byte(2, 8'hA5);
      bus.req_valid = 4'b0100;
      sb_q.push_back('{id: 2'd2, data: 8'hA5});
      do_transfer(1'b1, n);
      chk("single_latency", 32'(n), 32'd1);
      bus.req_valid = '0;

      // Pointer must now be 3: requesters 0 and 3 valid -> 3 wins.
      set_byte(0, 8'h20);
      set_byte(3, 8'h23);
      bus.req_valid = 4'b1001;
      sb_q.push_back('{id: 2'd3, data: 8'h23});
      do_transfer(1'b1, n);
      bus.req_valid = '0;

      // Transmitter busy: no grant until tx_empty rises.
      bus.tx_empty = 1'b0;
      set_byte(0, 8'h30);
      bus.req_valid = 4'b0001;
      repeat (5) begin
         @(negedge clk);
         chk("hold_ready", 32'(bus.req_ready), 32'd0);
         chk("hold_tx_ld", 32'(bus.tx_ld), 32'd0);
      end
      bus.tx_empty = 1'b1;
      sb_q.push_back('{id: 2'd0, data: 8'h30});
      do_transfer(1'b1, n);
      chk("release_latency", 32'(n), 32'd1);
      bus.req_valid = '0;

      // Requester 1 withdraws during GRANT (pointer is 1).
      set_byte(1, 8'h41);
      bus.req_valid = 4'b0010;
      wait_ready(n);
      chk("drop_ready", 32'(bus.req_ready), 32'b0010);
      bus.req_valid = '0;
      repeat (3) begin
         @(negedge clk);
         chk("drop_tx_ld", 32'(bus.tx_ld), 32'd0);
      end
      chk("drop_busy", 32'(bus.busy), 32'd0);
      for (int k = 0; k < 4; k++) set_byte(k, 8'(8'h50 + k));
      bus.req_valid = 4'b1111;
      sb_q.push_back('{id: 2'd1, data: 8'h51});
      do_transfer(1'b0, n);
      bus.req_valid = '0;

      // Reset asserted in WAIT_DONE, then released with the transmitter still busy.
      set_byte(2, 8'h66);
      bus.req_valid = 4'b0100;
      sb_q.push_back('{id: 2'd2, data: 8'h66});
      e = sb_q.pop_front();
      wait_ready(n);
      chk("mid_ready", 32'(bus.req_ready), 32'd1 << e.id);
      @(negedge clk);
      chk("mid_tx_data", 32'(bus.tx_data), 32'(e.data));
      bus.req_valid = '0;
      @(negedge clk);
      bus.tx_empty = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_busy", 32'(bus.busy), 32'd1);
      #2 rst = 1'b0;
      #1 chk_zero_outputs("async_rst");
      @(negedge clk);
      rst = 1'b1;
      set_byte(0, 8'h70);
      bus.req_valid = 4'b0001;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_ready", 32'(bus.req_ready), 32'd0);
         chk("post_rst_busy", 32'(bus.busy), 32'd0);
      end
      bus.tx_empty = 1'b1;
      sb_q.push_back('{id: 2'd0, data: 8'h70});
      do_transfer(1'b1, n);
      chk("post_rst_latency", 32'(n), 32'd1);
      bus.req_valid = '0;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=no finish expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
